// File: rtl/wisc_fetch_pkg.sv
// Shared types and constants for the WISC-S25 fetch stage.
package wisc_fetch_pkg;

  localparam logic [15:0] NOP_INSTR  = 16'hE000;
  localparam logic [3:0]  HLT_OPCODE = 4'hF;
  localparam logic [15:0] PC_MASK    = 16'hFFFE;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [15:0] pc_curr;
    logic [15:0] pc_next;
    logic [15:0] instr;
    logic [1:0]  prediction;
    logic [15:0] predicted_target;
    logic        valid;
  } if_id_t;

  function automatic if_id_t if_id_bubble();
    if_id_t b;
    b.pc_curr          = 16'h0000;
    b.pc_next          = 16'h0000;
    b.instr            = NOP_INSTR;
    b.prediction       = 2'b00;
    b.predicted_target = 16'h0000;
    b.valid            = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise hold; resets to a bubble.
module if_id_reg
  import wisc_fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t q_q;
  if_id_t q_d;

  always_comb begin
    q_d = q_q;
    if (flush) begin
      q_d = if_id_bubble();
    end else if (load) begin
      q_d = d;
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= if_id_bubble();
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register, RUN/HALTED FSM and next-PC mux feeding IF/ID.
// Define FETCH_PRED_EN to let the branch predictor steer the next PC.
module fetch_pc_unit
  import wisc_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_mispredicted,
  input  logic        actual_taken,
  input  logic [15:0] actual_target,
  input  logic [1:0]  prediction,
  input  logic [15:0] predicted_target,
  input  logic [15:0] instr,
  output logic [15:0] PC_curr,
  output logic        pred_enable,
  output logic [15:0] IF_ID_PC_curr,
  output logic [15:0] IF_ID_PC_next,
  output logic [15:0] IF_ID_instr,
  output logic [1:0]  IF_ID_prediction,
  output logic [15:0] IF_ID_predicted_target,
  output logic        IF_ID_valid,
  output logic        halted
);

  logic [15:0]  pc_q, pc_d;
  fetch_state_t state_q, state_d;
  logic [15:0]  pc_plus2;
  logic         if_load, if_flush;
  if_id_t       if_id_d, if_id_q;

  assign pc_plus2 = pc_q + 16'd2;

  always_comb begin
    pc_d     = pc_q;
    state_d  = state_q;
    if_load  = 1'b0;
    if_flush = 1'b0;

    if_id_d.pc_curr          = pc_q;
    if_id_d.pc_next          = pc_plus2;
    if_id_d.instr            = instr;
    if_id_d.predicted_target = predicted_target;
    if_id_d.valid            = 1'b1;
`ifdef FETCH_PRED_EN
    if_id_d.prediction       = prediction;
`else
    if_id_d.prediction       = prediction & 2'b00;
`endif

    // A redirect outranks a stall so the wrong-path instruction never lingers.
    if (branch_mispredicted) begin
      if (actual_taken) begin
        pc_d = actual_target & PC_MASK;
      end else begin
        pc_d = if_id_q.pc_next & PC_MASK;
      end
      if_flush = 1'b1;
      state_d  = RUN;
    end else if (stall) begin
      pc_d    = pc_q;
      state_d = state_q;
    end else begin
      case (state_q)
        RUN: begin
          if_load = 1'b1;
`ifdef FETCH_PRED_EN
          if (prediction[1]) begin
            pc_d = predicted_target & PC_MASK;
          end else begin
            pc_d = pc_plus2;
          end
`else
          pc_d = pc_plus2;
`endif
          if (instr[15:12] == HLT_OPCODE) begin
            pc_d    = pc_q;
            state_d = HALTED;
          end else begin
            state_d = RUN;
          end
        end
        HALTED: begin
          pc_d     = pc_q;
          if_flush = 1'b1;
        end
        default: begin
          state_d  = RUN;
          if_flush = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC & PC_MASK;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (if_load),
    .flush (if_flush),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign PC_curr                = pc_q;
  assign halted                 = (state_q == HALTED);
  assign IF_ID_PC_curr          = if_id_q.pc_curr;
  assign IF_ID_PC_next          = if_id_q.pc_next;
  assign IF_ID_instr            = if_id_q.instr;
  assign IF_ID_prediction       = if_id_q.prediction;
  assign IF_ID_predicted_target = if_id_q.predicted_target;
  assign IF_ID_valid            = if_id_q.valid;

`ifdef FETCH_PRED_EN
  assign pred_enable = ~stall & ~halted;
`else
  assign pred_enable = 1'b0;
`endif

endmodule
